// File: rtl/lfsr_rr_server.sv
// rtl/lfsr_rr_server.sv - shared 5-bit LFSR served to NREQ requesters by a round-robin arbiter
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   req[NREQ]         level requests; one LFSR value is consumed per grant
//   gnt[NREQ]         registered one-hot grant, one-cycle pulse
//   rnd_valid         registered, high together with any gnt bit
//   rnd_data[5]       LFSR value handed to the grantee (pre-advance)
//   rnd_id[IDW]       index of the grantee
//   seed_valid, seed  seed load request/value; zero seed is replaced by INIT
//   seed_ready        low only during the one-cycle SEED state
//   busy              high while in ARB or SEED
module lfsr_rr_server #(
    parameter int         NREQ = 4,
    parameter int         IDW  = 2,
    parameter logic [4:0] INIT = 5'b00001
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [4:0]      rnd_data,
    output logic [IDW-1:0]  rnd_id,
    input  logic            seed_valid,
    input  logic [4:0]      seed,
    output logic            seed_ready,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      lfsr_q, lfsr_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rnd_valid_q, rnd_valid_d;
    logic [4:0]      rnd_data_q, rnd_data_d;
    logic [IDW-1:0]  rnd_id_q, rnd_id_d;

    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  idx;
    int              tmp;

    // Round-robin search: first set request strictly after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        tmp   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            tmp = int'(rr_ptr_q) + i;
            if (tmp >= NREQ) begin
                tmp = tmp - NREQ;
            end
            idx = tmp[IDW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        rnd_id_d    = rnd_id_q;

        if (state_q == SEED) begin
            // Requests are deliberately ignored on the edge leaving SEED.
            state_d = (|req) ? ARB : IDLE;
        end else if (seed_valid) begin
            state_d = SEED;
            lfsr_d  = (seed == 5'd0) ? INIT : seed;
        end else if (found) begin
            state_d      = ARB;
            gnt_d[win]   = 1'b1;
            rnd_valid_d  = 1'b1;
            rnd_data_d   = lfsr_q;
            rnd_id_d     = win;
            lfsr_d       = {lfsr_q[0] ^ lfsr_q[2], lfsr_q[4:1]};
            rr_ptr_d     = win;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lfsr_q      <= INIT;
            rr_ptr_q    <= IDW'(NREQ - 1);
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= 5'd0;
            rnd_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            rnd_id_q    <= rnd_id_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd_valid  = rnd_valid_q;
    assign rnd_data   = rnd_data_q;
    assign rnd_id     = rnd_id_q;
    assign seed_ready = (state_q != SEED);
    assign busy       = (state_q == ARB) || (state_q == SEED);

endmodule
